// File: rtl/bit_stuffer.sv
// USB bit-stuffing stage: forwards the packet+CRC bit stream one bit per cycle and
// inserts a 0 after every STUFF_RUN consecutive ones, stalling upstream for the
// single cycle the stuffed bit occupies.
module bit_stuffer #(
   parameter int unsigned STUFF_RUN = 6
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       in_bit,
   input  logic       in_valid,
   output logic       bs_ready,
   output logic       out_bit,
   output logic       out_valid,
   output logic       pkt_done,
   output logic [7:0] stuff_count
);

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StStuff,
      StDone
   } state_e;

   // Run length widened by one bit so ones_cnt+1 can be compared without wrap.
   localparam logic [4:0] RunLen = 5'(STUFF_RUN);

   state_e     state_q, state_d;
   logic [3:0] ones_cnt_q, ones_cnt_d;
   logic       bs_ready_q, bs_ready_d;
   logic       out_bit_q, out_bit_d;
   logic       out_valid_q, out_valid_d;
   logic       pkt_done_q, pkt_done_d;
   logic [7:0] stuff_count_q, stuff_count_d;

   logic       accept;
   logic       run_hit;
   logic       first_hit;

   assign accept    = in_valid & bs_ready_q;
   // Accepted 1 completes a run when counted on top of the current ones_cnt.
   assign run_hit   = in_bit & (({1'b0, ones_cnt_q} + 5'd1) == RunLen);
   // First bit of a packet counts from zero regardless of leftover state.
   assign first_hit = in_bit & (RunLen == 5'd1);

   // Next-state and registered-output computation.
   always_comb begin
      state_d       = state_q;
      ones_cnt_d    = ones_cnt_q;
      out_bit_d     = out_bit_q;
      out_valid_d   = 1'b0;
      pkt_done_d    = 1'b0;
      stuff_count_d = stuff_count_q;

      case (state_q)
         StIdle, StDone: begin
            if (accept) begin
               out_bit_d     = in_bit;
               out_valid_d   = 1'b1;
               ones_cnt_d    = in_bit ? 4'd1 : 4'd0;
               stuff_count_d = 8'd0;
               state_d       = first_hit ? StStuff : StSend;
            end else begin
               ones_cnt_d = 4'd0;
               state_d    = StIdle;
            end
         end

         StSend: begin
            if (accept) begin
               out_bit_d   = in_bit;
               out_valid_d = 1'b1;
               ones_cnt_d  = in_bit ? (ones_cnt_q + 4'd1) : 4'd0;
               state_d     = run_hit ? StStuff : StSend;
            end else begin
               // Upstream went quiet: packet is over, flag it next cycle.
               ones_cnt_d = 4'd0;
               pkt_done_d = 1'b1;
               state_d    = StDone;
            end
         end

         StStuff: begin
            out_bit_d   = 1'b0;
            out_valid_d = 1'b1;
            ones_cnt_d  = 4'd0;
            if (stuff_count_q != 8'hFF) begin
               stuff_count_d = stuff_count_q + 8'd1;
            end
            state_d = StSend;
         end

         default: begin
            ones_cnt_d = 4'd0;
            state_d    = StIdle;
         end
      endcase
   end

   // Ready is registered: low only for the one cycle spent in StStuff.
   assign bs_ready_d = (state_d != StStuff);

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         ones_cnt_q    <= 4'd0;
         bs_ready_q    <= 1'b1;
         out_bit_q     <= 1'b0;
         out_valid_q   <= 1'b0;
         pkt_done_q    <= 1'b0;
         stuff_count_q <= 8'd0;
      end else begin
         state_q       <= state_d;
         ones_cnt_q    <= ones_cnt_d;
         bs_ready_q    <= bs_ready_d;
         out_bit_q     <= out_bit_d;
         out_valid_q   <= out_valid_d;
         pkt_done_q    <= pkt_done_d;
         stuff_count_q <= stuff_count_d;
      end
   end

   assign bs_ready    = bs_ready_q;
   assign out_bit     = out_bit_q;
   assign out_valid   = out_valid_q;
   assign pkt_done    = pkt_done_q;
   assign stuff_count = stuff_count_q;

endmodule

// File: tb/tb_bit_stuffer.sv
// Directed bench for bit_stuffer: one instance with STUFF_RUN=6, one with STUFF_RUN=3.
module tb_bit_stuffer;

   logic       clock;
   logic       reset_n;
   logic       in_bit;
   logic       in_valid;
   logic       sel;

   logic       in_valid6, in_valid3;
   logic       rdy6, ob6, ov6, pd6;
   logic       rdy3, ob3, ov3, pd3;
   logic [7:0] sc6, sc3;

   logic       o_ready, o_bit, o_valid, o_done;
   logic [7:0] o_count;

   int n_tests = 0;
   int n_fail  = 0;

   // Per-packet observations
   logic [31:0] out_v;
   int out_n, stall_n, stall0, stall1, done_at, last_out, gap;

   assign in_valid6 = in_valid & ~sel;
   assign in_valid3 = in_valid & sel;

   assign o_ready = sel ? rdy3 : rdy6;
   assign o_bit   = sel ? ob3  : ob6;
   assign o_valid = sel ? ov3  : ov6;
   assign o_done  = sel ? pd3  : pd6;
   assign o_count = sel ? sc3  : sc6;

   bit_stuffer #(.STUFF_RUN(6)) u_dut6 (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_bit     (in_bit),
      .in_valid   (in_valid6),
      .bs_ready   (rdy6),
      .out_bit    (ob6),
      .out_valid  (ov6),
      .pkt_done   (pd6),
      .stuff_count(sc6)
   );

   bit_stuffer #(.STUFF_RUN(3)) u_dut3 (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_bit     (in_bit),
      .in_valid   (in_valid3),
      .bs_ready   (rdy3),
      .out_bit    (ob3),
      .out_valid  (ov3),
      .pkt_done   (pd3),
      .stuff_count(sc3)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive n bits (bits[n-1] first) honouring bs_ready, then idle until pkt_done.
   // Cycle 0 is the first cycle the first bit is presented.
   task automatic run_pkt(input logic use3, input logic [31:0] bits, input int n);
      int idx;
      int cyc;
      sel = use3;
      idx = 0; cyc = 0;
      out_v = '0; out_n = 0; stall_n = 0; stall0 = -1; stall1 = -1;
      done_at = -1; last_out = -1; gap = 0;
      while (done_at < 0 && cyc < 200) begin
         @(negedge clock);
         if (o_valid) begin
            out_v = {out_v[30:0], o_bit};
            if (out_n > 0 && last_out != cyc - 1) gap = 1;
            out_n++;
            last_out = cyc;
         end
         if (!o_ready) begin
            if (stall_n == 0) stall0 = cyc;
            else if (stall_n == 1) stall1 = cyc;
            stall_n++;
         end
         if (o_done) done_at = cyc;
         if (idx < n) begin
            in_valid = 1'b1;
            in_bit   = bits[n-1-idx];
            if (o_ready) idx++;
         end else begin
            in_valid = 1'b0;
            in_bit   = 1'b0;
         end
         cyc++;
      end
      in_valid = 1'b0;
      if (done_at < 0) check("pkt_done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      reset_n  = 1'b0;
      in_bit   = 1'b0;
      in_valid = 1'b0;
      sel      = 1'b0;
      repeat (2) @(negedge clock);

      // Reset values on both instances
      check("rst_ready6", {31'd0, rdy6}, 32'd1);
      check("rst_valid6", {31'd0, ov6}, 32'd0);
      check("rst_bit6", {31'd0, ob6}, 32'd0);
      check("rst_done6", {31'd0, pd6}, 32'd0);
      check("rst_count6", {24'd0, sc6}, 32'd0);
      check("rst_ready3", {31'd0, rdy3}, 32'd1);
      check("rst_valid3", {31'd0, ov3}, 32'd0);
      reset_n = 1'b1;
      @(negedge clock);

      // 8 ones: 1,1,1,1,1,1,0,1,1
      run_pkt(1'b0, 32'b11111111, 8);
      check("t1_len", out_n, 9);
      check("t1_bits", out_v, 32'b111111011);
      check("t1_stalls", stall_n, 1);
      check("t1_stall_at", stall0, 6);
      check("t1_done_follows", done_at, last_out + 1);
      check("t1_gap", gap, 0);
      check("t1_count", {24'd0, o_count}, 32'd1);

      // Five ones then 0: no stuffing; starts right after pkt_done
      run_pkt(1'b0, 32'b11111010, 8);
      check("t2_len", out_n, 8);
      check("t2_bits", out_v, 32'b11111010);
      check("t2_stalls", stall_n, 0);
      check("t2_count", {24'd0, o_count}, 32'd0);

      // 12 ones: stuffed zeros after output bits 6 and 13
      run_pkt(1'b0, 32'b111111111111, 12);
      check("t3_len", out_n, 14);
      check("t3_bits", out_v, 32'b11111101111110);
      check("t3_stalls", stall_n, 2);
      check("t3_stall0", stall0, 6);
      check("t3_stall1", stall1, 13);
      check("t3_count", {24'd0, o_count}, 32'd2);

      // Packet ending on a full run: last output is the stuffed 0
      run_pkt(1'b0, 32'b010111111, 9);
      check("t4_len", out_n, 10);
      check("t4_bits", out_v, 32'b0101111110);
      check("t4_gap", gap, 0);
      check("t4_done_follows", done_at, last_out + 1);
      check("t4_count", {24'd0, o_count}, 32'd1);

      // Reset while in STUFF
      begin
         int found;
         found = 0;
         sel = 1'b0;
         for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clock);
            if (!o_ready) begin
               found    = 1;
               reset_n  = 1'b0;
               in_valid = 1'b0;
            end else begin
               in_valid = 1'b1;
               in_bit   = 1'b1;
            end
         end
         in_valid = 1'b0;
         check("t5_reached_stuff", found, 1);
         @(negedge clock);
         check("t5_ready", {31'd0, o_ready}, 32'd1);
         check("t5_valid", {31'd0, o_valid}, 32'd0);
         check("t5_count", {24'd0, o_count}, 32'd0);
         check("t5_done", {31'd0, o_done}, 32'd0);
         reset_n = 1'b1;
         @(negedge clock);
         check("t5_no_done", {31'd0, o_done}, 32'd0);
         check("t5_valid2", {31'd0, o_valid}, 32'd0);
      end
      run_pkt(1'b0, 32'b111110, 6);
      check("t5_len", out_n, 6);
      check("t5_bits", out_v, 32'b111110);
      check("t5_stalls", stall_n, 0);
      check("t5_count2", {24'd0, o_count}, 32'd0);

      // STUFF_RUN=3, seven ones: 1,1,1,0,1,1,1,0,1
      run_pkt(1'b1, 32'b1111111, 7);
      check("t6_len", out_n, 9);
      check("t6_bits", out_v, 32'b111011101);
      check("t6_stalls", stall_n, 2);
      check("t6_stall0", stall0, 3);
      check("t6_count", {24'd0, o_count}, 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
